// File: rtl/mem_line_responder_if.sv
// Line request bus for mem_line_responder: strobe/addr/rw/data_i in,
// done/data_o/busy back. master = requester, slave = responder.
interface mem_line_responder_if #(
  parameter int XLEN   = 32,
  parameter int CLSIZE = 128
);
  logic              strobe_i;
  logic [XLEN-1:0]   addr_i;
  logic              rw_i;
  logic [CLSIZE-1:0] data_i;
  logic              done_o;
  logic [CLSIZE-1:0] data_o;
  logic              busy_o;

  modport master (
    output strobe_i, addr_i, rw_i, data_i,
    input  done_o, data_o, busy_o
  );

  modport slave (
    input  strobe_i, addr_i, rw_i, data_i,
    output done_o, data_o, busy_o
  );
endinterface

// File: rtl/mem_line_responder.sv
// Line-wide strobe/done memory responder over a word-wide sync SRAM.
// Ports: clk_i, rst_n_i (async low), bus (slave: line req in, done/data/busy out).
module mem_line_responder #(
  parameter int XLEN      = 32,
  parameter int CLSIZE    = 128,
  parameter int N_ENTRIES = 16384,
  parameter int LATENCY   = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  mem_line_responder_if.slave  bus
);
  localparam int BEATS = CLSIZE / XLEN;
  localparam int BW    = $clog2(BEATS);
  localparam int AW    = $clog2(N_ENTRIES);
  localparam int IW    = AW - BW;
  localparam int OFF   = $clog2(CLSIZE / 8);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  localparam logic [7:0] WAIT_INIT =
    (LATENCY > 0) ? 8'(LATENCY - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE, WAIT, XFER, DONE
  } state_e;

  state_e state_q, state_n;

  logic [IW-1:0]     idx_q;
  logic              rw_q;
  logic [CLSIZE-1:0] wdata_q;
  logic [BW-1:0]     beat_q;
  logic [7:0]        wait_q;
  logic              rd_pend_q;
  logic [BW-1:0]     rd_lane_q;
  logic [XLEN-1:0]   rdata_q;
  logic [CLSIZE-1:0] data_q;
  logic              done_q;
  logic              busy_q;
  logic              accept;
  logic              issue;
  logic [AW-1:0]     word_addr;

  logic [XLEN-1:0] mem [N_ENTRIES];

  // Only the line-index bits select storage; the rest alias.
  logic unused_addr;
  assign unused_addr = ^bus.addr_i;

  assign word_addr = {idx_q, beat_q};

  always_comb begin
    state_n = state_q;
    accept  = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.strobe_i) begin
          accept  = 1'b1;
          state_n = (LATENCY > 0) ? WAIT : XFER;
        end
      end
      WAIT: begin
        if (wait_q == 8'd0)
          state_n = XFER;
      end
      XFER: begin
        issue = 1'b1;
        if (beat_q == LAST)
          state_n = DONE;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      beat_q    <= '0;
      wait_q    <= 8'd0;
      rd_pend_q <= 1'b0;
      rd_lane_q <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      // done trails DONE by one edge so it lines up with the last lane.
      done_q  <= (state_q == DONE);
      busy_q  <= (state_n != IDLE);
      if (accept) begin
        idx_q   <= bus.addr_i[OFF+IW-1:OFF];
        rw_q    <= bus.rw_i;
        wdata_q <= bus.data_i;
        beat_q  <= '0;
        wait_q  <= WAIT_INIT;
      end
      if (state_q == WAIT && wait_q != 8'd0)
        wait_q <= wait_q - 8'd1;
      if (issue)
        beat_q <= beat_q + BW'(1);
      // SRAM word arrives one edge after issue; lane it the edge after.
      rd_pend_q <= issue && !rw_q;
      rd_lane_q <= beat_q;
      if (rd_pend_q)
        data_q[rd_lane_q*XLEN +: XLEN] <= rdata_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue && rw_q)
      mem[word_addr] <= wdata_q[beat_q*XLEN +: XLEN];
    if (issue && !rw_q)
      rdata_q <= mem[word_addr];
  end

  assign bus.done_o = done_q;
  assign bus.data_o = data_q;
  assign bus.busy_o = busy_q;
endmodule
